multicycle_ctrl: RTL

Phase sequencer that converts the single-cycle decode path into a multicycle core sharing one unified instruction/data memory port. It receives the opcode and decoder enables (regWrite, MemWrite, MemToReg) and steps the datapath through fetch, decode, execute, memory and writeback phases. It drives phase-qualified register and memory enables, handles the memory req/ready handshake, and counts retired instructions.

---
 rtl/multicycle_pkg.sv | 20 ++
 rtl/mem_wait_timer.sv | 28 ++
 rtl/multicycle_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared state encodings, opcode constants and timeout default
package multicycle_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam int MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - memory ready-wait counter with timeout compare
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  output logic timeout
);

  logic [CNT_W-1:0] cnt;

  // Timeout fires on the wait cycle that finds the counter already at the limit.
  assign timeout = waiting && (cnt == CNT_W'(MEM_TIMEOUT));

  // Count consecutive stalled request cycles; any non-waiting cycle clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (waiting && !timeout) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle phase sequencer; optional MULTICYCLE_CTRL_TIMEOUT_EN memory-timeout fault
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        dec_regWrite,
  input  logic        dec_MemWrite,
  input  logic        dec_MemToReg,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        rf_latch,
  output logic        alu_latch,
  output logic        mdr_latch,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        pc_write,
  output logic        illegal,
  output logic        fault,
  output logic [2:0]  state_o,
  output logic [31:0] instret
);

  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_DECODE = ST_DECODE;
  localparam logic [2:0] S_EXEC   = ST_EXEC;
  localparam logic [2:0] S_MEM    = ST_MEM;
  localparam logic [2:0] S_WB     = ST_WB;
  localparam logic [2:0] S_FAULT  = ST_FAULT;

  logic [2:0]  state, next_state;
  logic [31:0] instret_q;
  logic        waiting, timeout, fault_c;
  logic        mem_req_c, mem_we_c, addr_sel_c, ir_write_c, rf_latch_c, alu_latch_c;
  logic        mdr_latch_c, reg_write_c, mem_to_reg_c, pc_write_c, illegal_c;

  // A memory request is outstanding but not yet accepted this cycle.
  assign waiting = ~mem_ready & (((state == S_FETCH) & run) | (state == S_MEM));

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .waiting (waiting),
    .timeout (timeout)
  );
  assign fault_c = (state == S_FAULT);
`else
  wire unused_cfg = (MEM_TIMEOUT < (1 << CNT_W));
  assign timeout = 1'b0;
  assign fault_c = 1'b0;
`endif

  // Phase decode: per-state enables and next-state selection.
  always_comb begin
    next_state   = state;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    addr_sel_c   = 1'b0;
    ir_write_c   = 1'b0;
    rf_latch_c   = 1'b0;
    alu_latch_c  = 1'b0;
    mdr_latch_c  = 1'b0;
    reg_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    pc_write_c   = 1'b0;
    illegal_c    = 1'b0;
    case (state)
      S_FETCH: begin
        if (run) begin
          mem_req_c = 1'b1;
          if (mem_ready) begin
            ir_write_c = 1'b1;
            next_state = S_DECODE;
          end else if (timeout) begin
            next_state = S_FAULT;
          end
        end
      end
      S_DECODE: begin
        rf_latch_c = 1'b1;
        next_state = S_EXEC;
      end
      S_EXEC: begin
        alu_latch_c = 1'b1;
        if (opcode == OP_LOAD || opcode == OP_STORE) begin
          next_state = S_MEM;
        end else if (opcode == OP_RTYPE || opcode == OP_ITYPE) begin
          next_state = S_WB;
        end else begin
          illegal_c  = 1'b1;
          pc_write_c = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        mem_we_c   = dec_MemWrite;
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_write_c = 1'b1;
            next_state = S_FETCH;
          end else begin
            mdr_latch_c = 1'b1;
            next_state  = S_WB;
          end
        end else if (timeout) begin
          next_state = S_FAULT;
        end
      end
      S_WB: begin
        reg_write_c  = dec_regWrite;
        mem_to_reg_c = dec_MemToReg;
        pc_write_c   = 1'b1;
        next_state   = S_FETCH;
      end
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_FETCH;
    endcase
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      instret_q <= '0;
    end else begin
      state <= next_state;
      if (pc_write_c) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  // Reset forces every output low in the same cycle, even mid-wait.
  assign mem_req    = ~rst & mem_req_c;
  assign mem_we     = ~rst & mem_we_c;
  assign addr_sel   = ~rst & addr_sel_c;
  assign ir_write   = ~rst & ir_write_c;
  assign rf_latch   = ~rst & rf_latch_c;
  assign alu_latch  = ~rst & alu_latch_c;
  assign mdr_latch  = ~rst & mdr_latch_c;
  assign reg_write  = ~rst & reg_write_c;
  assign mem_to_reg = ~rst & mem_to_reg_c;
  assign pc_write   = ~rst & pc_write_c;
  assign illegal    = ~rst & illegal_c;
  assign fault      = ~rst & fault_c;
  assign state_o    = rst ? 3'd0 : state;
  assign instret    = rst ? 32'd0 : instret_q;

endmodule
